// File: rtl/riscv_lsu_split.sv
// riscv_lsu_split: load/store unit that splits misaligned accesses into two aligned memory beats
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   core_req_i/we_i/size_i         core access request, store flag, RISC-V funct3 size
//   core_addr_i/wd_i               byte address, LSB-aligned store data
//   core_rd_o/stall_o/err_o        extended load result, hold request, rejected access pulse
//   mem_req_o/we_o/be_o/addr_o/wd_o beat request towards data memory (registered)
//   mem_gnt_i/rvalid_i/rd_i        beat accept, beat response, read data
module riscv_lsu_split #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                core_req_i,
    input  logic                core_we_i,
    input  logic [2:0]          core_size_i,
    input  logic [ADDR_W-1:0]   core_addr_i,
    input  logic [DATA_W-1:0]   core_wd_i,
    output logic [DATA_W-1:0]   core_rd_o,
    output logic                core_stall_o,
    output logic                core_err_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wd_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rd_i
);
    localparam int BE_W = DATA_W / 8;
    localparam int OW   = $clog2(BE_W);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ0  = 3'd1;
    localparam logic [2:0] WAIT0 = 3'd2;
    localparam logic [2:0] REQ1  = 3'd3;
    localparam logic [2:0] WAIT1 = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    localparam logic [2:0] ERR   = 3'd6;
    logic [2:0]          state, nxt;
    logic                we_q, we_c, idle, two_beat, illegal, nxt_req;
    logic [2:0]          size_q, size_c;
    logic [ADDR_W-1:0]   addr_q, addr_c, base;
    logic [DATA_W-1:0]   wd_q, wd_c, rd0_q, r0, sh, lmask, zx, res;
    logic [OW-1:0]       off;
    logic [2*BE_W-1:0]   bmask, m;
    logic [2*DATA_W-1:0] wdw, rdw;
    assign core_stall_o = core_req_i & ~(state == DONE | state == ERR);
    always_comb begin
        // In IDLE the live core inputs are used so beat 0 can be registered on the accept edge
        idle    = state == IDLE;
        we_c    = idle ? core_we_i : we_q;
        size_c  = idle ? core_size_i : size_q;
        addr_c  = idle ? core_addr_i : addr_q;
        wd_c    = idle ? core_wd_i : wd_q;
        off     = addr_c[OW-1:0];
        base    = {addr_c[ADDR_W-1:OW], {OW{1'b0}}};
        bmask   = size_c[1:0] == 2'd0 ? (2*BE_W)'(8'h01) :
                  size_c[1:0] == 2'd1 ? (2*BE_W)'(8'h03) :
                  size_c[1:0] == 2'd2 ? (2*BE_W)'(8'h0F) : (2*BE_W)'(8'hFF);
        m        = bmask << off;
        wdw      = {{DATA_W{1'b0}}, wd_c} << {off, 3'b000};
        two_beat = |m[2*BE_W-1:BE_W];
        illegal  = size_c == 3'd7 || (DATA_W == 32 && (size_c == 3'd3 || size_c == 3'd6));
        // Single-beat loads read both halves from the same word; the upper copy is truncated away
        r0    = state == WAIT0 ? mem_rd_i : rd0_q;
        rdw   = {mem_rd_i, r0} >> {off, 3'b000};
        sh    = rdw[DATA_W-1:0];
        lmask = size_c[1:0] == 2'd0 ? DATA_W'(8'hFF) :
                size_c[1:0] == 2'd1 ? DATA_W'(16'hFFFF) :
                size_c[1:0] == 2'd2 ? DATA_W'(32'hFFFF_FFFF) : '1;
        zx    = sh & lmask;
        // Sign bit is the top bit of the access mask
        res   = (!size_c[2] && |(sh & lmask & ~(lmask >> 1))) ? zx | ~lmask : zx;
        nxt   = state;
        case (state)
            IDLE:    if (core_req_i) nxt = (illegal || (two_beat && !MISALIGN_SPLIT)) ? ERR : REQ0;
            REQ0:    if (mem_gnt_i) nxt = WAIT0;
            WAIT0:   if (mem_rvalid_i) nxt = two_beat ? REQ1 : DONE;
            REQ1:    if (mem_gnt_i) nxt = WAIT1;
            WAIT1:   if (mem_rvalid_i) nxt = DONE;
            default: nxt = IDLE;
        endcase
        nxt_req = nxt == REQ0 || nxt == REQ1;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wd_q       <= '0;
            rd0_q      <= '0;
            core_rd_o  <= '0;
            core_err_o <= 1'b0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_be_o   <= '0;
            mem_addr_o <= '0;
            mem_wd_o   <= '0;
        end else begin
            state <= nxt;
            if (idle && core_req_i) begin
                we_q   <= core_we_i;
                size_q <= core_size_i;
                addr_q <= core_addr_i;
                wd_q   <= core_wd_i;
            end
            if (state == WAIT0 && mem_rvalid_i) rd0_q <= mem_rd_i;
            if (nxt == DONE && !we_c) core_rd_o <= res;
            core_err_o <= nxt == ERR;
            mem_req_o  <= nxt_req;
            mem_we_o   <= nxt_req && we_c;
            mem_be_o   <= nxt == REQ0 ? m[BE_W-1:0] : nxt == REQ1 ? m[2*BE_W-1:BE_W] : '0;
            mem_wd_o   <= nxt == REQ0 ? wdw[DATA_W-1:0] : nxt == REQ1 ? wdw[2*DATA_W-1:DATA_W] : '0;
            mem_addr_o <= nxt == REQ0 ? base : nxt == REQ1 ? base + ADDR_W'(BE_W) : '0;
        end
    end
endmodule

// File: tb/tb_riscv_lsu_split.sv
// tb_riscv_lsu_split: directed vectors for the split LSU in 32-bit split, 32-bit reject and 64-bit builds
module tb_riscv_lsu_split;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    int checks = 0, passed = 0;

    // 32-bit, splitting
    logic a_req = 0, a_we = 0, a_gnt = 0, a_rvalid = 0;
    logic [2:0] a_size = 0;
    logic [31:0] a_addr = 0, a_wd = 0, a_mrd = 0;
    logic [31:0] a_crd, a_maddr, a_mwd;
    logic a_stall, a_err, a_mreq, a_mwe;
    logic [3:0] a_mbe;
    // 32-bit, rejecting misaligned
    logic e_req = 0, e_gnt = 0, e_rvalid = 0;
    logic [31:0] e_addr = 0, e_mrd = 0;
    logic [31:0] e_crd, e_maddr, e_mwd;
    logic e_stall, e_err, e_mreq, e_mwe;
    logic [3:0] e_mbe;
    // 64-bit
    logic w_req = 0, w_gnt = 0, w_rvalid = 0;
    logic [2:0] w_size = 0;
    logic [31:0] w_addr = 0;
    logic [63:0] w_mrd = 0;
    logic [63:0] w_crd, w_mwd;
    logic [31:0] w_maddr;
    logic w_stall, w_err, w_mreq, w_mwe;
    logic [7:0] w_mbe;

    riscv_lsu_split #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .core_req_i(a_req), .core_we_i(a_we), .core_size_i(a_size),
        .core_addr_i(a_addr), .core_wd_i(a_wd), .core_rd_o(a_crd), .core_stall_o(a_stall),
        .core_err_o(a_err), .mem_req_o(a_mreq), .mem_we_o(a_mwe), .mem_be_o(a_mbe),
        .mem_addr_o(a_maddr), .mem_wd_o(a_mwd), .mem_gnt_i(a_gnt), .mem_rvalid_i(a_rvalid),
        .mem_rd_i(a_mrd));
    riscv_lsu_split #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b0)) u_e (
        .clk_i(clk), .rst_ni(rst_n), .core_req_i(e_req), .core_we_i(1'b0), .core_size_i(3'd2),
        .core_addr_i(e_addr), .core_wd_i(32'h0), .core_rd_o(e_crd), .core_stall_o(e_stall),
        .core_err_o(e_err), .mem_req_o(e_mreq), .mem_we_o(e_mwe), .mem_be_o(e_mbe),
        .mem_addr_o(e_maddr), .mem_wd_o(e_mwd), .mem_gnt_i(e_gnt), .mem_rvalid_i(e_rvalid),
        .mem_rd_i(e_mrd));
    riscv_lsu_split #(.DATA_W(64), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) u_w (
        .clk_i(clk), .rst_ni(rst_n), .core_req_i(w_req), .core_we_i(1'b0), .core_size_i(w_size),
        .core_addr_i(w_addr), .core_wd_i(64'h0), .core_rd_o(w_crd), .core_stall_o(w_stall),
        .core_err_o(w_err), .mem_req_o(w_mreq), .mem_we_o(w_mwe), .mem_be_o(w_mbe),
        .mem_addr_o(w_maddr), .mem_wd_o(w_mwd), .mem_gnt_i(w_gnt), .mem_rvalid_i(w_rvalid),
        .mem_rd_i(w_mrd));

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr, wd, rd0, rd1;
        int          beats;
        logic [3:0]  be0, be1;
        logic [31:0] a0, a1, wd0, wd1, rd;
        int          cyc;
        logic        err;
    } vec_t;
    vec_t v [13];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", n, act, exp);
    endtask

    // One access on u_a: gnt in the first request cycle, rvalid the cycle after gnt
    task automatic run(input int i);
        vec_t t = v[i];
        int done = 0, nb = 0, pend = 0;
        logic [31:0] ga [2], gwd [2];
        logic [3:0] gbe [2];
        logic gwe [2];
        logic [31:0] rd = 0;
        logic er = 0;
        a_req = 1; a_we = t.we; a_size = t.size; a_addr = t.addr; a_wd = t.wd;
        for (int c = 2; c <= 30 && done == 0; c++) begin
            @(negedge clk);
            a_gnt = 0; a_rvalid = 0;
            if (!a_stall) begin
                done = c; rd = a_crd; er = a_err;
            end else if (pend != 0) begin
                a_rvalid = 1; a_mrd = pend == 1 ? t.rd0 : t.rd1; pend = 0;
            end else if (a_mreq && nb < 2) begin
                a_gnt = 1; ga[nb] = a_maddr; gbe[nb] = a_mbe; gwd[nb] = a_mwd; gwe[nb] = a_mwe;
                nb++; pend = nb;
            end
        end
        chk({t.name, "_cycles"}, done, t.cyc);
        chk({t.name, "_beats"}, nb, t.beats);
        chk({t.name, "_err"}, er, t.err);
        chk({t.name, "_rd"}, rd, t.rd);
        for (int b = 0; b < 2; b++) if (b < t.beats) begin
            chk($sformatf("%s_addr%0d", t.name, b), ga[b], b == 0 ? t.a0 : t.a1);
            chk($sformatf("%s_be%0d", t.name, b), gbe[b], b == 0 ? t.be0 : t.be1);
            chk($sformatf("%s_wd%0d", t.name, b), gwd[b], b == 0 ? t.wd0 : t.wd1);
            chk($sformatf("%s_we%0d", t.name, b), gwe[b], t.we);
        end
        a_req = 0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int held;
        v[0]  = '{"lw_al", 0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0, 1, 4'hF, 0, 32'h100, 0, 0, 0, 32'hDEADBEEF, 4, 0};
        v[1]  = '{"lb", 0, 3'd0, 32'h103, 0, 32'h80FFFFFF, 0, 1, 4'h8, 0, 32'h100, 0, 0, 0, 32'hFFFFFF80, 4, 0};
        v[2]  = '{"lbu", 0, 3'd4, 32'h103, 0, 32'h80FFFFFF, 0, 1, 4'h8, 0, 32'h100, 0, 0, 0, 32'h00000080, 4, 0};
        v[3]  = '{"lw_split", 0, 3'd2, 32'h102, 0, 32'hAABB1234, 32'h5678CCDD, 2, 4'hC, 4'h3, 32'h100, 32'h104, 0, 0, 32'hCCDDAABB, 6, 0};
        v[4]  = '{"sh_split", 1, 3'd1, 32'h203, 32'h1234, 32'h11111111, 32'h22222222, 2, 4'h8, 4'h1, 32'h200, 32'h204, 32'h34000000, 32'h00000012, 32'hCCDDAABB, 6, 0};
        v[5]  = '{"lh", 0, 3'd1, 32'h106, 0, 32'h80010000, 0, 1, 4'hC, 0, 32'h104, 0, 0, 0, 32'hFFFF8001, 4, 0};
        v[6]  = '{"lhu_split", 0, 3'd5, 32'h107, 0, 32'h7F000000, 32'h000000FE, 2, 4'h8, 4'h1, 32'h104, 32'h108, 0, 0, 32'h0000FE7F, 6, 0};
        v[7]  = '{"sw", 1, 3'd2, 32'h0, 32'hCAFEF00D, 0, 0, 1, 4'hF, 0, 32'h0, 0, 32'hCAFEF00D, 0, 32'h0000FE7F, 4, 0};
        v[8]  = '{"lw_wrap", 0, 3'd2, 32'hFFFFFFFE, 0, 32'h9ABC0000, 32'h00005678, 2, 4'hC, 4'h3, 32'hFFFFFFFC, 32'h0, 0, 0, 32'h56789ABC, 6, 0};
        v[9]  = '{"ld_illegal", 0, 3'd3, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h56789ABC, 2, 1};
        v[10] = '{"lwu_illegal", 0, 3'd6, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h56789ABC, 2, 1};
        v[11] = '{"lb_pos", 0, 3'd0, 32'h101, 0, 32'h00007F00, 0, 1, 4'h2, 0, 32'h100, 0, 0, 0, 32'h0000007F, 4, 0};
        v[12] = '{"sb", 1, 3'd0, 32'h302, 32'hA5, 0, 0, 1, 4'h4, 0, 32'h300, 0, 32'h00A50000, 0, 32'h0000007F, 4, 0};

        repeat (2) @(negedge clk);
        chk("rst_rd", a_crd, 0);
        chk("rst_ctl", {a_err, a_mreq, a_mwe, a_mbe}, 0);
        chk("rst_addr", a_maddr, 0);
        chk("rst_wd", a_mwd, 0);
        rst_n = 1;
        @(negedge clk);
        chk("idle_stall_low", a_stall, 0);
        for (int i = 0; i < 13; i++) run(i);

        // Misaligned rejection: error pulse in cycle 2, no memory traffic
        e_req = 1; e_addr = 32'h101;
        @(negedge clk);
        chk("rej_err", e_err, 1);
        chk("rej_stall", e_stall, 0);
        chk("rej_mreq", e_mreq, 0);
        e_req = 0;
        @(negedge clk);
        chk("rej_err_pulse", e_err, 0);
        chk("rej_mreq2", e_mreq, 0);
        e_req = 1; e_addr = 32'h100;
        @(negedge clk);
        chk("rej_al_mreq", e_mreq, 1);
        e_gnt = 1;
        @(negedge clk);
        e_gnt = 0; e_rvalid = 1; e_mrd = 32'h13579BDF;
        @(negedge clk);
        e_rvalid = 0;
        chk("rej_al_stall", e_stall, 0);
        chk("rej_al_rd", e_crd, 32'h13579BDF);
        e_req = 0;
        @(negedge clk);

        // 64-bit LD with gnt held off three cycles
        w_req = 1; w_size = 3'd3; w_addr = 32'h8;
        held = 0;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            if (w_mreq && w_maddr == 32'h8 && w_mbe == 8'hFF && !w_mwe && w_mwd == 0) held++;
            w_gnt = c == 5;
        end
        chk("d64_held", held, 4);
        @(negedge clk);
        w_gnt = 0;
        chk("d64_req_drop", w_mreq, 0);
        w_rvalid = 1; w_mrd = 64'h0123456789ABCDEF;
        @(negedge clk);
        w_rvalid = 0;
        chk("d64_stall", w_stall, 0);
        chk("d64_rd", w_crd, 64'h0123456789ABCDEF);
        w_req = 0;
        @(negedge clk);

        // Reset during WAIT0 aborts; the late response is ignored
        w_req = 1; w_addr = 32'h10;
        @(negedge clk);
        chk("abort_mreq", w_mreq, 1);
        w_gnt = 1;
        @(negedge clk);
        w_gnt = 0;
        rst_n = 0;
        #1;
        chk("abort_rd", w_crd, 0);
        chk("abort_ctl", {w_err, w_mreq, w_mwe, w_mbe}, 0);
        chk("abort_addr", w_maddr, 0);
        chk("abort_wd", w_mwd, 0);
        chk("abort_stall", w_stall, 1);
        w_req = 0;
        @(negedge clk);
        rst_n = 1; w_rvalid = 1; w_mrd = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        w_rvalid = 0;
        chk("late_rd", w_crd, 0);
        chk("late_mreq", w_mreq, 0);
        w_req = 1; w_size = 3'd2; w_addr = 32'h4;
        @(negedge clk);
        chk("lw64_addr", w_maddr, 32'h0);
        chk("lw64_be", w_mbe, 8'hF0);
        w_gnt = 1;
        @(negedge clk);
        w_gnt = 0; w_rvalid = 1; w_mrd = 64'h80000001_00000000;
        @(negedge clk);
        w_rvalid = 0;
        chk("lw64_stall", w_stall, 0);
        chk("lw64_rd", w_crd, 64'hFFFFFFFF_80000001);
        w_req = 0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
